// File: rtl/kernel_bc_fifo_param_srl.sv
// Parametrised shift-register stream FIFO: show-ahead head, occupancy count,
// registered full/empty/almost flags and sticky overflow/underflow errors.
module kernel_bc_fifo_param_srl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] if_din,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  output logic [DATA_WIDTH-1:0] if_dout,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic                  if_empty_n,
  output logic                  if_almost_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_err_ovf,
  output logic                  if_err_udf
);
  typedef logic [ADDR_WIDTH:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_C    = cnt_t'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  cnt_t count, count_next, rd_idx;
  logic wr, rd, rd_ok, wr_ok;

  always_comb begin
    wr         = if_write & if_write_ce;
    rd         = if_read & if_read_ce;
    rd_ok      = rd & (count != '0);
    // a full FIFO still takes a write when the head leaves in the same edge
    wr_ok      = wr & ((count != DEPTH_C) | rd_ok);
    count_next = count;
    if (wr_ok & ~rd_ok)      count_next = count + 1'b1;
    else if (rd_ok & ~wr_ok) count_next = count - 1'b1;
    rd_idx     = (count == '0) ? '0 : count - 1'b1;
  end

  // Storage is not reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk)
    if (reset_n && wr_ok) srl[0] <= if_din;

  for (genvar i = 1; i < DEPTH; i++) begin : g_srl
    always_ff @(posedge clk)
      if (reset_n && wr_ok) srl[i] <= srl[i-1];
  end

  assign if_dout           = srl[rd_idx[ADDR_WIDTH-1:0]];
  assign if_num_data_valid = count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count             <= '0;
      if_empty_n        <= 1'b0;
      if_full_n         <= 1'b1;
      if_almost_empty_n <= 1'b0;
      if_almost_full_n  <= 1'b1;
      if_err_ovf        <= 1'b0;
      if_err_udf        <= 1'b0;
    end else begin
      count             <= count_next;
      if_empty_n        <= (count_next != '0);
      if_full_n         <= (count_next != DEPTH_C);
      if_almost_empty_n <= ~(count_next <= AE_C);
      if_almost_full_n  <= ~(count_next >= AF_C);
      if (wr & ~wr_ok)          if_err_ovf <= 1'b1;
      if (rd & (count == '0))   if_err_udf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kernel_bc_fifo_param_srl.sv
// Directed and model-checked bench for the SRL FIFO at DEPTH=8 and DEPTH=2.
module tb_kernel_bc_fifo_param_srl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] din;
  logic        write, write_ce, read, read_ce;
  logic        full_n, afull_n, empty_n, aempty_n, ovf, udf;
  logic [63:0] dout;
  logic [3:0]  cnt;
  logic        full2_n, afull2_n, empty2_n, aempty2_n, ovf2, udf2;
  logic [63:0] dout2;
  logic [1:0]  cnt2;
  int total = 0;
  int bad   = 0;
  logic [63:0] q8[$];
  logic [63:0] q2[$];

  always #5 clk = ~clk;

  kernel_bc_fifo_param_srl #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .DEPTH(8),
                             .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .reset_n(reset_n), .if_din(din), .if_write(write),
    .if_write_ce(write_ce), .if_full_n(full_n), .if_almost_full_n(afull_n),
    .if_dout(dout), .if_read(read), .if_read_ce(read_ce), .if_empty_n(empty_n),
    .if_almost_empty_n(aempty_n), .if_num_data_valid(cnt),
    .if_err_ovf(ovf), .if_err_udf(udf));

  kernel_bc_fifo_param_srl #(.DATA_WIDTH(64), .ADDR_WIDTH(1), .DEPTH(2),
                             .AF_LEVEL(1), .AE_LEVEL(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .if_din(din), .if_write(write),
    .if_write_ce(write_ce), .if_full_n(full2_n), .if_almost_full_n(afull2_n),
    .if_dout(dout2), .if_read(read), .if_read_ce(read_ce), .if_empty_n(empty2_n),
    .if_almost_empty_n(aempty2_n), .if_num_data_valid(cnt2),
    .if_err_ovf(ovf2), .if_err_udf(udf2));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [63:0] d);
    write = w; read = r; din = d; write_ce = 1'b1; read_ce = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; drive(0, 0, '0); tick(); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; drive(1, 1, 64'hdead); tick();
    total++;
    if ({cnt, empty_n, full_n, aempty_n, afull_n, ovf, udf} !== {4'd0, 6'b010100}) begin
      bad++; $display("FAIL reset: got cnt=%0d flags=%b want cnt=0 flags=010100", cnt,
                      {empty_n, full_n, aempty_n, afull_n, ovf, udf});
    end
    reset_n = 1'b1; drive(0, 0, '0);
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 64'(i)); tick();
      total++;
      if (cnt !== 4'(i) || full_n !== (i != 8) || afull_n !== !(i >= 6) ||
          aempty_n !== !(i <= 2) || empty_n !== 1'b1 || dout !== 64'h1) begin
        bad++; $display("FAIL fill[%0d]: cnt=%0d fn=%b afn=%b aen=%b en=%b dout=%h want cnt=%0d dout=1",
                        i, cnt, full_n, afull_n, aempty_n, empty_n, dout, i);
      end
    end
    drive(0, 0, '0);
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (dout !== 64'(i)) begin
        bad++; $display("FAIL drain_data[%0d]: got %h want %h", i, dout, 64'(i));
      end
      drive(0, 1, '0); tick();
      total++;
      if (cnt !== 4'(8 - i) || empty_n !== (i != 8) || aempty_n !== !((8 - i) <= 2) ||
          full_n !== 1'b1 || udf !== 1'b0) begin
        bad++; $display("FAIL drain_flags[%0d]: cnt=%0d en=%b aen=%b fn=%b udf=%b want cnt=%0d",
                        i, cnt, empty_n, aempty_n, full_n, udf, 8 - i);
      end
    end
    drive(0, 0, '0);
  endtask

  task automatic test_full_rw();
    logic [63:0] exp;
    for (int i = 1; i <= 8; i++) begin drive(1, 0, 64'(i)); tick(); end
    drive(1, 1, 64'hAA); tick();
    total++;
    if (cnt !== 4'd8 || full_n !== 1'b0 || dout !== 64'h2 || ovf !== 1'b0) begin
      bad++; $display("FAIL full_rw: cnt=%0d fn=%b dout=%h ovf=%b want cnt=8 fn=0 dout=2 ovf=0",
                      cnt, full_n, dout, ovf);
    end
    for (int i = 2; i <= 9; i++) begin
      exp = (i == 9) ? 64'hAA : 64'(i);
      total++;
      if (dout !== exp) begin
        bad++; $display("FAIL full_rw_order[%0d]: got %h want %h", i, dout, exp);
      end
      drive(0, 1, '0); tick();
    end
    drive(0, 0, '0);
  endtask

  task automatic test_empty_rw();
    drive(1, 1, 64'h55); tick();
    total++;
    if (cnt !== 4'd1 || dout !== 64'h55 || empty_n !== 1'b1 || udf !== 1'b1) begin
      bad++; $display("FAIL empty_rw: cnt=%0d dout=%h en=%b udf=%b want cnt=1 dout=55 en=1 udf=1",
                      cnt, dout, empty_n, udf);
    end
    drive(0, 0, '0);
  endtask

  task automatic test_ce();
    do_reset();
    drive(1, 0, 64'h77); write_ce = 1'b0; tick();
    total++;
    if (cnt !== 4'd0 || empty_n !== 1'b0) begin
      bad++; $display("FAIL write_ce: cnt=%0d en=%b want cnt=0 en=0", cnt, empty_n);
    end
    drive(0, 1, '0); read_ce = 1'b0; tick();
    total++;
    if (udf !== 1'b0) begin
      bad++; $display("FAIL read_ce: udf=%b want 0", udf);
    end
    drive(0, 0, '0);
  endtask

  task automatic test_errors();
    do_reset();
    for (int i = 0; i < 8; i++) begin drive(1, 0, 64'h10 + 64'(i)); tick(); end
    drive(1, 0, 64'hEE); tick();
    total++;
    if (ovf !== 1'b1 || udf !== 1'b0 || cnt !== 4'd8 || dout !== 64'h10) begin
      bad++; $display("FAIL ovf: ovf=%b udf=%b cnt=%0d dout=%h want ovf=1 udf=0 cnt=8 dout=10",
                      ovf, udf, cnt, dout);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dout !== 64'h10 + 64'(i)) begin
        bad++; $display("FAIL ovf_contents[%0d]: got %h want %h", i, dout, 64'h10 + 64'(i));
      end
      drive(0, 1, '0); tick();
    end
    drive(0, 1, '0); tick();
    total++;
    if (udf !== 1'b1 || ovf !== 1'b1 || cnt !== 4'd0) begin
      bad++; $display("FAIL udf: udf=%b ovf=%b cnt=%0d want 1 1 0", udf, ovf, cnt);
    end
    drive(0, 0, '0); repeat (3) tick();
    total++;
    if ({ovf, udf} !== 2'b11) begin
      bad++; $display("FAIL err_sticky: got %b want 11", {ovf, udf});
    end
    do_reset();
    total++;
    if ({ovf, udf} !== 2'b00) begin
      bad++; $display("FAIL err_clear: got %b want 00", {ovf, udf});
    end
  endtask

  task automatic test_random();
    logic w, r, ok_r8, ok_w8, ok_r2, ok_w2, e_ovf8, e_udf8, e_ovf2, e_udf2;
    logic [63:0] d;
    int s8, s2, wp;
    do_reset();
    q8.delete(); q2.delete();
    e_ovf8 = 0; e_udf8 = 0; e_ovf2 = 0; e_udf2 = 0;
    for (int c = 0; c < 10000; c++) begin
      wp = ((c / 500) % 2 == 0) ? 70 : 30;
      w = ($urandom_range(99) < wp); r = ($urandom_range(99) < (100 - wp));
      d = {$urandom, $urandom};
      if (c == 5000) begin
        reset_n = 1'b0; drive(w, r, d); tick(); reset_n = 1'b1;
        q8.delete(); q2.delete();
        e_ovf8 = 0; e_udf8 = 0; e_ovf2 = 0; e_udf2 = 0;
      end else begin
        drive(w, r, d);
        s8 = q8.size(); s2 = q2.size();
        ok_r8 = r && s8 != 0; ok_w8 = w && (s8 != 8 || ok_r8);
        ok_r2 = r && s2 != 0; ok_w2 = w && (s2 != 2 || ok_r2);
        if (w && !ok_w8) e_ovf8 = 1;
        if (r && s8 == 0) e_udf8 = 1;
        if (w && !ok_w2) e_ovf2 = 1;
        if (r && s2 == 0) e_udf2 = 1;
        if (ok_r8) void'(q8.pop_front());
        if (ok_w8) q8.push_back(d);
        if (ok_r2) void'(q2.pop_front());
        if (ok_w2) q2.push_back(d);
        tick();
      end
      s8 = q8.size(); s2 = q2.size();
      total++;
      if (cnt !== 4'(s8) ||
          {empty_n, full_n, afull_n, aempty_n, ovf, udf} !==
          {s8 != 0, s8 != 8, !(s8 >= 6), !(s8 <= 2), e_ovf8, e_udf8} ||
          (s8 != 0 && dout !== q8[0])) begin
        bad++; $display("FAIL rand8[%0d]: cnt=%0d flags=%b dout=%h want cnt=%0d head=%h",
                        c, cnt, {empty_n, full_n, afull_n, aempty_n, ovf, udf}, dout, s8,
                        (s8 != 0) ? q8[0] : 64'h0);
      end
      total++;
      if (cnt2 !== 2'(s2) ||
          {empty2_n, full2_n, afull2_n, aempty2_n, ovf2, udf2} !==
          {s2 != 0, s2 != 2, !(s2 >= 1), !(s2 <= 0), e_ovf2, e_udf2} ||
          (s2 != 0 && dout2 !== q2[0])) begin
        bad++; $display("FAIL rand2[%0d]: cnt=%0d flags=%b dout=%h want cnt=%0d head=%h",
                        c, cnt2, {empty2_n, full2_n, afull2_n, aempty2_n, ovf2, udf2}, dout2,
                        s2, (s2 != 0) ? q2[0] : 64'h0);
      end
    end
    drive(0, 0, '0);
  endtask

  initial begin
    reset_n = 1'b1; drive(0, 0, '0);
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_ce();
    test_errors();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
